// File: rtl/cyclic_prefix_insertion.sv
// Buffers one FFT_LEN-sample symbol, then replays its last CP_LEN samples followed by the whole symbol.
// First output 1 cycle after the last input; out_TREADY low holds the presented sample, in_TVALID low pauses the fill.
module cyclic_prefix_insertion #(
    parameter int FFT_LEN = 64,
    parameter int CP_LEN  = 16,
    parameter int DATA_W  = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [DATA_W-1:0] in_TDATA,
    input  logic              in_TVALID,
    output logic              in_TREADY,
    output logic [DATA_W-1:0] out_TDATA,
    output logic              out_TVALID,
    input  logic              out_TREADY
);
    localparam int CW = $clog2(FFT_LEN + 1);
    localparam int AW = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FILL     = 3'd1;
    localparam logic [2:0] S_EMIT_CP  = 3'd2;
    localparam logic [2:0] S_EMIT_SYM = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [CW-1:0] WR_LAST   = CW'(FFT_LEN - 1);
    localparam logic [CW-1:0] CP_LAST   = CW'(CP_LEN - 1);
    localparam logic [AW-1:0] CP_BASE   = AW'(FFT_LEN - CP_LEN);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FFT_LEN - 1);

    logic [2:0]        r_state;
    logic [CW-1:0]     r_wr_cnt;
    logic [CW-1:0]     r_rd_cnt;
    logic [DATA_W-1:0] r_buf [FFT_LEN];

    logic              w_in_hs;
    logic              w_in_last;
    logic              w_out_hs;
    logic [AW-1:0]     w_rd_addr;
    logic [DATA_W-1:0] w_rd_dat;

    assign in_TREADY = (r_state == S_FILL);
    assign w_in_hs   = in_TREADY && in_TVALID;
    assign w_in_last = w_in_hs && (r_wr_cnt == WR_LAST);
    assign w_out_hs  = out_TVALID && out_TREADY;
    assign ap_ready  = w_in_last;
    assign ap_idle   = (r_state == S_IDLE);
    assign ap_done   = (r_state == S_DONE);

    // Address of the sample to be presented after the current transfer.
    always_comb begin
        w_rd_addr = CP_BASE;
        case (r_state)
            S_EMIT_CP:  w_rd_addr = (r_rd_cnt == CP_LAST) ? '0 : AW'(CP_BASE + r_rd_cnt + 1);
            S_EMIT_SYM: w_rd_addr = (r_rd_cnt == WR_LAST) ? '0 : AW'(r_rd_cnt + 1);
            default:    w_rd_addr = CP_BASE;
        endcase
        w_rd_dat = r_buf[w_rd_addr];
        // With a one-sample prefix the first output is the sample being written this very cycle.
        if (r_state == S_FILL && CP_BASE == LAST_ADDR) begin
            w_rd_dat = in_TDATA;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_in_hs) begin
            r_buf[r_wr_cnt[AW-1:0]] <= in_TDATA;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state    <= S_IDLE;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            out_TVALID <= 1'b0;
            out_TDATA  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_state  <= S_FILL;
                        r_wr_cnt <= '0;
                    end
                end
                S_FILL: begin
                    if (w_in_hs) begin
                        r_wr_cnt <= r_wr_cnt + CW'(1);
                        if (w_in_last) begin
                            r_state    <= S_EMIT_CP;
                            r_rd_cnt   <= '0;
                            out_TVALID <= 1'b1;
                            out_TDATA  <= w_rd_dat;
                        end
                    end
                end
                S_EMIT_CP: begin
                    if (w_out_hs) begin
                        out_TDATA <= w_rd_dat;
                        if (r_rd_cnt == CP_LAST) begin
                            r_state  <= S_EMIT_SYM;
                            r_rd_cnt <= '0;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + CW'(1);
                        end
                    end
                end
                S_EMIT_SYM: begin
                    if (w_out_hs) begin
                        if (r_rd_cnt == WR_LAST) begin
                            r_state    <= S_DONE;
                            out_TVALID <= 1'b0;
                        end else begin
                            r_rd_cnt  <= r_rd_cnt + CW'(1);
                            out_TDATA <= w_rd_dat;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cyclic_prefix_insertion.md
CYCLIC_PREFIX_INSERTION -- requirements
Module: cyclic_prefix_insertion

Interface
REQ-001 Parameter FFT_LEN, default 64: samples per OFDM symbol; legal range 2..1024.
REQ-002 Parameter CP_LEN, default 16: cyclic prefix length; legal range 1..FFT_LEN.
REQ-003 Parameter DATA_W, default 32: sample width, packed {Q[31:16], I[15:0]}.
REQ-004 Port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port ap_rst, input, 1 bit: reset; synchronous to ap_clk and active-high.
REQ-006 Port ap_start, input, 1 bit: start request for one symbol.
REQ-007 Port ap_done, output, 1 bit: one-cycle pulse when the last output sample is accepted.
REQ-008 Port ap_idle, output, 1 bit: high only while the FSM is in IDLE.
REQ-009 Port ap_ready, output, 1 bit: one-cycle pulse when the last input sample is accepted.
REQ-010 Port in_TDATA, input, DATA_W bits: input sample.
REQ-011 Port in_TVALID, input, 1 bit: input sample valid.
REQ-012 Port in_TREADY, output, 1 bit: block accepts an input sample.
REQ-013 Port out_TDATA, output, DATA_W bits: output sample.
REQ-014 Port out_TVALID, output, 1 bit: output sample valid.
REQ-015 Port out_TREADY, input, 1 bit: downstream accepts an output sample.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, EMIT_CP, EMIT_SYM and DONE.
REQ-017 In IDLE with ap_start=1, the FSM SHALL enter FILL on the next edge; with ap_start=0 it SHALL stay in IDLE.
REQ-018 In FILL, in_TREADY SHALL be 1, and each in_TVALID&in_TREADY handshake SHALL write buffer[wr_cnt] and increment wr_cnt.
REQ-019 Outside FILL, in_TREADY SHALL be 0.
REQ-020 On the handshake with wr_cnt=FFT_LEN-1, the block SHALL pulse ap_ready for exactly that cycle and SHALL enter EMIT_CP on the next edge.
REQ-021 The counters wr_cnt and rd_cnt SHALL each be clog2(FFT_LEN+1) bits wide and SHALL be cleared on entry to FILL, EMIT_CP and EMIT_SYM.
REQ-022 out_TDATA and out_TVALID SHALL be registered outputs; out_TVALID SHALL rise on the first cycle of EMIT_CP.
REQ-023 In EMIT_CP, outputs SHALL be buffer[FFT_LEN-CP_LEN+rd_cnt] for rd_cnt = 0..CP_LEN-1.
REQ-024 In EMIT_SYM, outputs SHALL be buffer[rd_cnt] for rd_cnt = 0..FFT_LEN-1.
REQ-025 A transfer SHALL occur only when out_TVALID&out_TREADY; otherwise out_TDATA and out_TVALID SHALL hold unchanged.
REQ-026 After a transfer, the next sample SHALL be presented on the following cycle, with no bubble between EMIT_CP and EMIT_SYM.
REQ-027 Exactly FFT_LEN+CP_LEN samples SHALL be emitted per start.
REQ-028 On the transfer of the last EMIT_SYM sample, out_TVALID SHALL drop on the next edge, the FSM SHALL enter DONE, and ap_done SHALL be 1 for that single DONE cycle; DONE SHALL then return to IDLE.
REQ-029 Minimum latency SHALL be: first output valid 1 cycle after the last input handshake; ap_done 1 cycle after the last output handshake.
REQ-030 ap_start SHALL be ignored outside IDLE.
REQ-031 If ap_start is held high, a new FILL SHALL begin the cycle after IDLE is re-entered, giving a 2-cycle gap from the ap_done cycle.
REQ-032 With CP_LEN=FFT_LEN, the prefix SHALL be the whole symbol.
REQ-033 in_TVALID=0 in FILL and out_TREADY=0 in the EMIT states SHALL stall indefinitely without loss or duplication.

Reset
REQ-034 While ap_rst=1 at a rising edge, the FSM SHALL go to IDLE; wr_cnt, rd_cnt, out_TVALID, ap_done and ap_ready SHALL be set to 0, out_TDATA SHALL be set to 0, and ap_idle SHALL be 1 on the following cycle.
REQ-035 A reset applied mid-FILL or mid-EMIT SHALL abandon the symbol, and no further output SHALL be produced until a new ap_start.
REQ-036 Buffer contents need not be reset.

Verification
REQ-037 FFT_LEN=8, CP_LEN=2, inputs 0..7 with ready always high -> outputs 6,7,0,1,2,3,4,5,6,7 on 10 consecutive cycles; ap_ready pulses on the input-7 cycle; ap_done pulses once, 1 cycle after the last output.
REQ-038 Same configuration with out_TREADY toggling 1,0,1,0,... -> the same 10-sample sequence, each value held through its stall cycle, and no duplicates.
REQ-039 Same configuration with in_TVALID gaps of 3 cycles between samples -> identical output sequence, and ap_ready fires only on the 8th accepted sample.
REQ-040 ap_rst asserted after 5 outputs -> next cycle out_TVALID=0 and ap_idle=1; a new start with inputs 10..17 -> outputs 16,17,10..17.
REQ-041 ap_start held high across two symbols -> two complete 10-sample sequences, ap_done pulses twice, and ap_start pulses while busy have no effect.
REQ-042 CP_LEN=FFT_LEN=8 -> 16 outputs: 0..7 followed by 0..7.
